// File: rtl/abs_diff_err_monitor_if.sv
// Port bundle between the error monitor and the approximate abs_diff candidate under test.
interface abs_diff_err_monitor_if #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 3
);
    logic                  start;
    logic [IN_W-1:0]       vec_o;
    logic [OUT_W-1:0]      approx_i;
    logic                  busy;
    logic                  done;
    logic                  res_valid;
    logic [OUT_W-1:0]      max_err;
    logic [IN_W:0]         err_cnt;
    logic [OUT_W+IN_W-1:0] sum_err;
    logic                  pass;
    logic                  fail_valid;
    logic [IN_W-1:0]       fail_vec;

    modport master (
        input  start, approx_i,
        output vec_o, busy, done, res_valid, max_err, err_cnt, sum_err, pass,
               fail_valid, fail_vec
    );

    modport slave (
        output start, approx_i,
        input  vec_o, busy, done, res_valid, max_err, err_cnt, sum_err, pass,
               fail_valid, fail_vec
    );
endinterface

// File: rtl/abs_diff_err_monitor.sv
// Exhaustive scan of an approximate |a-b| circuit, accumulating max/count/sum of error.
// Optional first-failure capture is enabled by defining ABS_DIFF_ERR_MON_FAIL_CAPTURE_EN.
module abs_diff_err_monitor #(
    parameter int unsigned IN_W    = 4,
    parameter int unsigned OUT_W   = 3,
    parameter int unsigned ET      = 3,
    parameter int unsigned DUT_LAT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    abs_diff_err_monitor_if.master bus
);
    localparam int unsigned HALF_W = IN_W / 2;
    localparam int unsigned CNT_W  = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
    localparam int unsigned SUM_W  = OUT_W + IN_W;

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  max_q, max_d;
    logic [IN_W:0]     errc_q, errc_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rv_q, rv_d;
    logic              pass_q, pass_d;

    logic [HALF_W-1:0] op_a, op_b;
    logic [HALF_W:0]   diff;
    logic [OUT_W-1:0]  exact, err;

    // Reference |a-b| for the current vector and its distance from the candidate output
    always_comb begin
        op_a  = vec_q[HALF_W-1:0];
        op_b  = vec_q[IN_W-1:HALF_W];
        diff  = (op_a >= op_b) ? ((HALF_W+1)'(op_a) - (HALF_W+1)'(op_b))
                               : ((HALF_W+1)'(op_b) - (HALF_W+1)'(op_a));
        exact = OUT_W'(diff);
        err   = (bus.approx_i >= exact) ? (bus.approx_i - exact) : (exact - bus.approx_i);
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        errc_d  = errc_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        rv_d    = rv_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    vec_d   = '0;
                    cnt_d   = CNT_W'(DUT_LAT);
                    max_d   = '0;
                    errc_d  = '0;
                    sum_d   = '0;
                    rv_d    = 1'b0;
                    pass_d  = 1'b0;
                    state_d = (DUT_LAT == 0) ? CHECK : SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = CHECK;
            end
            CHECK: begin
                max_d  = (err > max_q) ? err : max_q;
                errc_d = errc_q + (IN_W+1)'(err != '0);
                sum_d  = sum_q + SUM_W'(err);
                if (vec_q == {IN_W{1'b1}}) begin
                    done_d  = 1'b1;
                    rv_d    = 1'b1;
                    pass_d  = (32'(max_d) <= ET);
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + IN_W'(1);
                    cnt_d   = CNT_W'(DUT_LAT);
                    state_d = (DUT_LAT == 0) ? CHECK : SETTLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            errc_q  <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            errc_q  <= errc_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rv_q    <= rv_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.vec_o     = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = rv_q;
    assign bus.max_err   = max_q;
    assign bus.err_cnt   = errc_q;
    assign bus.sum_err   = sum_q;
    assign bus.pass      = pass_q;

`ifdef ABS_DIFF_ERR_MON_FAIL_CAPTURE_EN
    logic            fv_q;
    logic [IN_W-1:0] fvec_q;

    // Keep only the first vector whose error exceeds the threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q   <= 1'b0;
            fvec_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            fv_q   <= 1'b0;
            fvec_q <= '0;
        end else if (state_q == CHECK && !fv_q && (32'(err) > ET)) begin
            fv_q   <= 1'b1;
            fvec_q <= vec_q;
        end
    end

    assign bus.fail_valid = fv_q;
    assign bus.fail_vec   = fvec_q;
`else
    assign bus.fail_valid = 1'b0;
    assign bus.fail_vec   = '0;
`endif
endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// Scoreboard bench: two monitors (DUT_LAT=0/ET=3 and DUT_LAT=2/ET=2) against a table-driven candidate.
module tb_abs_diff_err_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   cand [16];

    typedef struct {
        int start_cyc;
        int done_cyc;
        int mx;
        int cnt;
        int sum;
        int ps;
        int fv;
        int fvec;
    } exp_t;

    exp_t q0 [$];
    exp_t q2 [$];
    int   bad0 = 0;
    int   bad2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    abs_diff_err_monitor_if #(.IN_W(4), .OUT_W(3)) if0 ();
    abs_diff_err_monitor_if #(.IN_W(4), .OUT_W(3)) if2 ();

    abs_diff_err_monitor #(.IN_W(4), .OUT_W(3), .ET(3), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    abs_diff_err_monitor #(.IN_W(4), .OUT_W(3), .ET(2), .DUT_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));

    // Candidate circuits: table lookup, direct and through a 2-stage pipe
    logic [2:0] d1, d2;
    assign if0.approx_i = 3'(cand[if0.vec_o]);
    always @(posedge clk) begin
        d1 <= 3'(cand[if2.vec_o]);
        d2 <= d1;
    end
    assign if2.approx_i = d2;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic exp_t model(int et, int lat, int s);
        exp_t e;
        e.start_cyc = s;
        e.done_cyc  = s + 16 * (lat + 1) + 1;
        e.mx = 0; e.cnt = 0; e.sum = 0; e.fv = 0; e.fvec = 0;
        for (int v = 0; v < 16; v++) begin
            int a, b, ex, er;
            a  = v % 4;
            b  = v / 4;
            ex = (a > b) ? a - b : b - a;
            er = (cand[v] > ex) ? cand[v] - ex : ex - cand[v];
            if (er > e.mx) e.mx = er;
            if (er != 0) e.cnt++;
            e.sum += er;
            if (er > et && e.fv == 0) begin
                e.fv   = 1;
                e.fvec = v;
            end
        end
        e.ps = (e.mx <= et) ? 1 : 0;
`ifndef ABS_DIFF_ERR_MON_FAIL_CAPTURE_EN
        e.fv = 0;
        e.fvec = 0;
`endif
        return e;
    endfunction

    function automatic void check_done(string t, exp_t e, int now, int mx, int cnt, int sum,
                                       int ps, int rv, int fv, int fvec, int vec, int bad);
        chk({t, "_done_cycle"}, now, e.done_cyc);
        chk({t, "_max_err"}, mx, e.mx);
        chk({t, "_err_cnt"}, cnt, e.cnt);
        chk({t, "_sum_err"}, sum, e.sum);
        chk({t, "_pass"}, ps, e.ps);
        chk({t, "_res_valid"}, rv, 1);
        chk({t, "_fail_valid"}, fv, e.fv);
        chk({t, "_fail_vec"}, fvec, e.fvec);
        chk({t, "_last_vec"}, vec, 15);
        chk({t, "_vec_trace"}, bad, 0);
    endfunction

    // Monitor for the zero-latency instance
    always @(negedge clk) begin
        if (rst_n && if0.done) begin
            if (q0.size() == 0) chk("m0_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q0.pop_front();
                check_done("m0", e, cyc, int'(if0.max_err), int'(if0.err_cnt), int'(if0.sum_err),
                           int'(if0.pass), int'(if0.res_valid), int'(if0.fail_valid),
                           int'(if0.fail_vec), int'(if0.vec_o), bad0);
                bad0 = 0;
            end
        end else if (rst_n && q0.size() > 0) begin
            int c;
            c = cyc - q0[0].start_cyc;
            if (c >= 1 && c <= 16 && (int'(if0.vec_o) != c - 1 || !if0.busy)) bad0++;
        end
    end

    // Monitor for the two-cycle-latency instance
    always @(negedge clk) begin
        if (rst_n && if2.done) begin
            if (q2.size() == 0) chk("m2_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q2.pop_front();
                check_done("m2", e, cyc, int'(if2.max_err), int'(if2.err_cnt), int'(if2.sum_err),
                           int'(if2.pass), int'(if2.res_valid), int'(if2.fail_valid),
                           int'(if2.fail_vec), int'(if2.vec_o), bad2);
                bad2 = 0;
            end
        end else if (rst_n && q2.size() > 0) begin
            int c;
            c = cyc - q2[0].start_cyc;
            if (c >= 1 && c <= 48 && (int'(if2.vec_o) != (c - 1) / 3 || !if2.busy)) bad2++;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start held for one cycle from the current (post-edge) point
    task automatic pulse(int id, bit accept);
        if (id == 0) begin
            if0.start = 1'b1;
            if (accept) q0.push_back(model(3, 0, cyc));
        end else begin
            if2.start = 1'b1;
            if (accept) q2.push_back(model(2, 2, cyc));
        end
        step(1);
        if0.start = 1'b0;
        if2.start = 1'b0;
    endtask

    task automatic wait_idle(int id);
        for (int i = 0; i < 200; i++) begin
            if ((id == 0 ? q0.size() : q2.size()) == 0) break;
            step(1);
        end
        if (id == 0) begin
            chk("scan_complete0", q0.size(), 0);
            q0.delete();
        end else begin
            chk("scan_complete2", q2.size(), 0);
            q2.delete();
        end
        step(2);
    endtask

    task automatic check_zero(string t);
        chk({t, "_busy"}, int'(if0.busy), 0);
        chk({t, "_done"}, int'(if0.done), 0);
        chk({t, "_res_valid"}, int'(if0.res_valid), 0);
        chk({t, "_max_err"}, int'(if0.max_err), 0);
        chk({t, "_err_cnt"}, int'(if0.err_cnt), 0);
        chk({t, "_sum_err"}, int'(if0.sum_err), 0);
        chk({t, "_pass"}, int'(if0.pass), 0);
        chk({t, "_vec_o"}, int'(if0.vec_o), 0);
        chk({t, "_fail_valid"}, int'(if0.fail_valid), 0);
        chk({t, "_fail_vec"}, int'(if0.fail_vec), 0);
    endtask

    task automatic set_exact();
        for (int v = 0; v < 16; v++) cand[v] = (v % 4 > v / 4) ? v % 4 - v / 4 : v / 4 - v % 4;
    endtask

    task automatic set_const(int k);
        for (int v = 0; v < 16; v++) cand[v] = k;
    endtask

    initial begin
        exp_t e;
        if0.start = 1'b0;
        if2.start = 1'b0;
        set_exact();
        step(3);
        check_zero("reset");
        chk("reset_busy2", int'(if2.busy), 0);
        rst_n = 1'b1;
        step(2);

        // Loopback with an ignored start mid-scan
        pulse(0, 1);
        step(4);
        pulse(0, 0);
        wait_idle(0);

        // All-zero candidate on both thresholds
        set_const(0);
        pulse(0, 1);
        wait_idle(0);
        pulse(2, 1);
        wait_idle(2);

        // All-seven candidate, then start in the done cycle and the cycle after
        set_const(7);
        pulse(0, 1);
        step(16);
        pulse(0, 0);
        pulse(0, 1);
        chk("b2b_cleared_res_valid", int'(if0.res_valid), 0);
        chk("b2b_cleared_max_err", int'(if0.max_err), 0);
        chk("b2b_cleared_sum_err", int'(if0.sum_err), 0);
        chk("b2b_busy", int'(if0.busy), 1);
        wait_idle(0);
        e = model(3, 0, 0);
        chk("hold_busy", int'(if0.busy), 0);
        chk("hold_vec_o", int'(if0.vec_o), 15);
        chk("hold_res_valid", int'(if0.res_valid), 1);
        chk("hold_err_cnt", int'(if0.err_cnt), e.cnt);

        // Reset mid-scan, then a clean scan
        for (int v = 0; v < 16; v++) cand[v] = int'($urandom_range(0, 7));
        pulse(0, 1);
        step(7);
        rst_n = 1'b0;
        #1;
        q0.delete();
        check_zero("midreset");
        step(1);
        rst_n = 1'b1;
        step(25);
        pulse(0, 1);
        wait_idle(0);

        // Latency-2 loopback and random candidates on both instances
        set_exact();
        pulse(2, 1);
        wait_idle(2);
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < 16; v++) cand[v] = int'($urandom_range(0, 7));
            pulse(0, 1);
            wait_idle(0);
            pulse(2, 1);
            wait_idle(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/abs_diff_err_monitor.md
Name: abs_diff_err_monitor

Overview:
Sequential exhaustive error monitor that sits on the opposite side of an approximate abs_diff SOP netlist's ports.
- Drives every input vector into the candidate circuit and receives its outputs.
- Compares each output against the exact |a-b| result.
- Accumulates error statistics and reports pass/fail against the error threshold.
- Used in hardware-in-the-loop checking of approximate circuits from the synthesis flow.

Parameters:
IN_W, 4, candidate input width; even; operands a = vec[IN_W/2-1:0], b = vec[IN_W-1:IN_W/2]
OUT_W, 3, candidate output width; exact result zero-extended to OUT_W
ET, 3, error threshold; pass when max error <= ET
DUT_LAT, 0, cycles between vec_o change and approx_i being valid

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a scan when idle
vec_o  out  IN_W  input vector driven to candidate circuit
approx_i  in  OUT_W  candidate circuit outputs
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse when the scan completes
res_valid  out  1  results valid; held until next start
max_err  out  OUT_W  maximum |approx - exact| over the scan
err_cnt  out  IN_W+1  number of vectors with nonzero error
sum_err  out  OUT_W+IN_W  sum of absolute errors
pass  out  1  (max_err <= ET); meaningful only while res_valid
fail_valid  out  1  first-failure capture valid (optional feature)
fail_vec  out  IN_W  first vector with error > ET (optional feature)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, state IDLE.
  - pass resets to 0.
- States and transitions:
  - IDLE: on start, go to SETTLE. Set vec_o=0, wait counter=DUT_LAT. Clear max_err, err_cnt, sum_err, res_valid, fail_valid, fail_vec.
  - SETTLE: decrement the wait counter. Go to CHECK when it reaches 0.
  - CHECK: sample approx_i and apply the error update below.
    - If vec_o == 2^IN_W-1, go to DONE.
    - Otherwise increment vec_o, reload the counter, and go to SETTLE.
    - With DUT_LAT=0, SETTLE is skipped and CHECK repeats each cycle.
  - DONE: done=1 for exactly one cycle, res_valid=1, go to IDLE.
- busy=1 in SETTLE, CHECK and DONE.
- Error update in CHECK:
  - exact = |a-b|, computed unsigned at IN_W/2+1 bits and zero-extended to OUT_W.
  - err = |approx_i - exact| at OUT_W bits.
  - max_err = max(max_err, err).
  - err_cnt += (err != 0).
  - sum_err += err. Widths are chosen so neither counter can overflow.
- pass is registered as (max_err_final <= ET) in DONE.
- Timing: the start cycle is cycle 0, and vec_o=0 is visible from cycle 1.
  - Each vector occupies DUT_LAT+1 cycles.
  - done is high in cycle 2^IN_W*(DUT_LAT+1)+1.
- start while busy is ignored; it does not restart the scan.
- start in the same cycle as done is ignored; a start in the following IDLE cycle is accepted.
- vec_o holds its last value (2^IN_W-1) in IDLE after a scan.
- Results (max_err, err_cnt, sum_err, pass) hold until the next accepted start.
- Reset asserted mid-scan: immediate return to IDLE with all outputs 0. No done pulse is produced.

Optional Feature:
- Macro ABS_DIFF_ERR_MON_FAIL_CAPTURE_EN.
- Defined:
  - On the first CHECK where err > ET, latch fail_vec = vec_o and set fail_valid=1.
  - Later failures do not overwrite the capture.
  - Both are cleared on accepted start and on reset.
  - The scan always runs to completion.
- Undefined: fail_valid and fail_vec are tied to 0 and no capture logic exists.

Test Plan:
- Loopback candidate (approx_i = exact), defaults, start at cycle 0 -> done in cycle 17; max_err=0, err_cnt=0, sum_err=0, pass=1.
- approx_i constant 0, ET=3 -> max_err=3, err_cnt=12, sum_err=20, pass=1. Same stimulus with ET=2 -> pass=0.
- approx_i constant 7 -> max_err=7, err_cnt=16, sum_err=92, pass=0. With the feature enabled -> fail_valid=1, fail_vec=0.
- DUT_LAT=2, loopback through a 2-stage delay -> done in cycle 49, max_err=0, vec_o steps every 3 cycles.
- Pulse start at cycle 5 during a scan -> ignored, done still at cycle 17. Assert rst_n low at cycle 8 -> all outputs 0 immediately and no done pulse. A new start then completes normally.
- Back-to-back scans: start on the cycle after done -> results cleared on acceptance, second done 17 cycles later with identical values.
